// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the two-port memory arbiter.
// Handshake: a requester raises i_req / d_rd / d_wr with a stable address (and
// write data) and holds it until the matching *_done pulse; the memory side
// completes an access in the cycle mem_done=1, and mem_stall=1 means "try again
// next cycle with the same request still driven".
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_data_out;
    logic              i_done;
    logic              i_err;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_data_in;
    logic [DATA_W-1:0] d_data_out;
    logic              d_done;
    logic              d_err;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_err;
    logic              busy;
    logic              proto_err;
    logic [31:0]       perf_stall;
    logic [31:0]       perf_igrant;
    logic [31:0]       perf_dgrant;

    modport slave (
        input  i_req, i_addr, d_rd, d_wr, d_addr, d_data_in,
        input  mem_data_out, mem_done, mem_stall, mem_err,
        output i_data_out, i_done, i_err, d_data_out, d_done, d_err,
        output mem_rd, mem_wr, mem_addr, mem_data_in,
        output busy, proto_err, perf_stall, perf_igrant, perf_dgrant
    );

    modport master (
        output i_req, i_addr, d_rd, d_wr, d_addr, d_data_in,
        output mem_data_out, mem_done, mem_stall, mem_err,
        input  i_data_out, i_done, i_err, d_data_out, d_done, d_err,
        input  mem_rd, mem_wr, mem_addr, mem_data_in,
        input  busy, proto_err, perf_stall, perf_igrant, perf_dgrant
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter in front of one stalling unified memory.
// Data wins by default; a fetch that has watched MAX_WAIT data completions
// wins the next free arbitration. A stalled access locks the grant until done.
// Optional build macro MEM_ARB_PERF_EN adds stall/grant performance counters.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {LOCK_NONE, LOCK_I, LOCK_D} lock_t;

    lock_t      lock, lock_next, sel;
    logic [2:0] wait_cnt;
    logic       proto_q;
    logic       d_req, active, issue, starve, drop;
    logic       i_done, d_done;

    assign d_req  = bus.d_rd | bus.d_wr;
    assign starve = (wait_cnt >= 3'(MAX_WAIT));

    // Pick the requester served this cycle: the locked one, else arbitrate.
    always_comb begin
        sel = LOCK_NONE;
        if (lock == LOCK_NONE) begin
            if (d_req && !(bus.i_req && starve)) sel = LOCK_D;
            else if (bus.i_req)                  sel = LOCK_I;
        end else begin
            sel = lock;
        end
    end

    // An access is on the bus only while the selected requester still asks;
    // reset kills the strobes immediately, independent of the clock.
    assign active = ((sel == LOCK_I) && bus.i_req) || ((sel == LOCK_D) && d_req);
    assign issue  = active && rst_n;
    assign drop   = (lock != LOCK_NONE) && !active;

    // Drive the memory port from the selected requester; rd+wr together is a write.
    always_comb begin
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        if (issue && sel == LOCK_I) begin
            bus.mem_rd   = 1'b1;
            bus.mem_addr = bus.i_addr;
        end else if (issue && sel == LOCK_D) begin
            bus.mem_rd      = bus.d_rd & ~bus.d_wr;
            bus.mem_wr      = bus.d_wr;
            bus.mem_addr    = bus.d_addr;
            bus.mem_data_in = bus.d_data_in;
        end
    end

    assign i_done         = issue && (sel == LOCK_I) && bus.mem_done;
    assign d_done         = issue && (sel == LOCK_D) && bus.mem_done;
    assign bus.i_done     = i_done;
    assign bus.d_done     = d_done;
    assign bus.i_err      = i_done & bus.mem_err;
    assign bus.d_err      = d_done & bus.mem_err;
    assign bus.i_data_out = i_done ? bus.mem_data_out : '0;
    assign bus.d_data_out = d_done ? bus.mem_data_out : '0;
    assign bus.busy       = (lock != LOCK_NONE);
    assign bus.proto_err  = proto_q;

    // Next lock: completion frees, stall holds the current winner, a dropped
    // request abandons the lock without a done.
    always_comb begin
        lock_next = lock;
        if (issue && bus.mem_done)       lock_next = LOCK_NONE;
        else if (issue && bus.mem_stall) lock_next = sel;
        else if (!active)                lock_next = LOCK_NONE;
    end

    // Lock register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock <= LOCK_NONE;
        else        lock <= lock_next;
    end

    // Starvation counter: data completions seen by a waiting fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   wait_cnt <= 3'd0;
        else if (i_done)                              wait_cnt <= 3'd0;
        else if (d_done && bus.i_req && wait_cnt != 3'd7) wait_cnt <= wait_cnt + 3'd1;
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 proto_q <= 1'b0;
        else if ((bus.d_rd && bus.d_wr) || drop)    proto_q <= 1'b1;
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_igrant_q, perf_dgrant_q;

    // Wrapping stall / completion counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q  <= 32'd0;
            perf_igrant_q <= 32'd0;
            perf_dgrant_q <= 32'd0;
        end else begin
            if (bus.mem_stall) perf_stall_q  <= perf_stall_q + 32'd1;
            if (i_done)        perf_igrant_q <= perf_igrant_q + 32'd1;
            if (d_done)        perf_dgrant_q <= perf_dgrant_q + 32'd1;
        end
    end

    assign bus.perf_stall  = perf_stall_q;
    assign bus.perf_igrant = perf_igrant_q;
    assign bus.perf_dgrant = perf_dgrant_q;
`else
    assign bus.perf_stall  = 32'd0;
    assign bus.perf_igrant = 32'd0;
    assign bus.perf_dgrant = 32'd0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios for mem_arbiter with an expected-data
// scoreboard per requester. Inputs change at the falling edge; outputs are
// sampled 1 time unit later, well before the next rising edge.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] exp_i_q[$];
    logic [31:0] exp_d_q[$];
    logic [31:0] exp_v;
    logic [31:0] rd;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        bus.i_req        = 1'b0;
        bus.i_addr       = '0;
        bus.d_rd         = 1'b0;
        bus.d_wr         = 1'b0;
        bus.d_addr       = '0;
        bus.d_data_in    = '0;
        bus.mem_data_out = '0;
        bus.mem_done     = 1'b0;
        bus.mem_stall    = 1'b0;
        bus.mem_err      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        bus.i_req = 1'b1;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%0d exp=0", bus.mem_rd); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0d exp=0", bus.busy); end
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto got=%0d exp=0", bus.proto_err); end
        checks++; if (bus.perf_stall !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", bus.perf_stall); end
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin failures++; $display("FAIL idle_strobes got=%0d%0d exp=00", bus.mem_rd, bus.mem_wr); end
    endtask

    task automatic test_zero_latency();
        @(negedge clk);
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0010;
        bus.mem_done = 1'b1;
        rd = $urandom;
        bus.mem_data_out = rd;
        exp_i_q.push_back(rd);
        #1;
        checks++; if (bus.mem_rd !== 1'b1) begin failures++; $display("FAIL zl_mem_rd got=%0d exp=1", bus.mem_rd); end
        checks++; if (bus.mem_addr !== 16'h0010) begin failures++; $display("FAIL zl_mem_addr got=%h exp=0010", bus.mem_addr); end
        checks++; if (bus.i_done !== 1'b1) begin failures++; $display("FAIL zl_i_done got=%0d exp=1", bus.i_done); end
        checks++; if (bus.d_done !== 1'b0) begin failures++; $display("FAIL zl_d_done got=%0d exp=0", bus.d_done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zl_busy got=%0d exp=0", bus.busy); end
        if (bus.i_done === 1'b1 && exp_i_q.size() > 0) begin
            exp_v = exp_i_q.pop_front();
            checks++; if (bus.i_data_out !== exp_v) begin failures++; $display("FAIL zl_i_data got=%h exp=%h", bus.i_data_out, exp_v); end
        end
        @(negedge clk);
        drive_idle();
        bus.mem_data_out = 32'hdead_beef;
        #1;
        checks++; if (bus.i_data_out !== 32'd0) begin failures++; $display("FAIL zl_data_idle got=%h exp=0", bus.i_data_out); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL zl_busy_after got=%0d exp=0", bus.busy); end
    endtask

    task automatic test_stall_write();
        logic [31:0] wdata;
        wdata = $urandom;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.i_req = 1'b1;
            bus.i_addr = 16'h0020;
            bus.d_wr = 1'b1;
            bus.d_addr = 16'h0040;
            bus.d_data_in = wdata;
            bus.mem_stall = (c < 3);
            bus.mem_done = (c == 3);
            #1;
            checks++; if (bus.mem_wr !== 1'b1) begin failures++; $display("FAIL sw_mem_wr c=%0d got=%0d exp=1", c, bus.mem_wr); end
            checks++; if (bus.mem_addr !== 16'h0040) begin failures++; $display("FAIL sw_mem_addr c=%0d got=%h exp=0040", c, bus.mem_addr); end
            checks++; if (bus.mem_data_in !== wdata) begin failures++; $display("FAIL sw_wdata c=%0d got=%h exp=%h", c, bus.mem_data_in, wdata); end
            checks++; if (bus.i_done !== 1'b0) begin failures++; $display("FAIL sw_i_done c=%0d got=%0d exp=0", c, bus.i_done); end
            checks++; if (bus.d_done !== (c == 3)) begin failures++; $display("FAIL sw_d_done c=%0d got=%0d exp=%0d", c, bus.d_done, (c == 3)); end
            checks++; if (bus.busy !== (c > 1)) begin failures++; $display("FAIL sw_busy c=%0d got=%0d exp=%0d", c, bus.busy, (c > 1)); end
        end
        @(negedge clk);
        bus.d_wr = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_stall = 1'b0;
        rd = $urandom;
        bus.mem_data_out = rd;
        exp_i_q.push_back(rd);
        #1;
        checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0020) begin failures++; $display("FAIL sw_i_issue got=%0d/%h exp=1/0020", bus.mem_rd, bus.mem_addr); end
        checks++; if (bus.i_done !== 1'b1) begin failures++; $display("FAIL sw_i_done_after got=%0d exp=1", bus.i_done); end
        if (bus.i_done === 1'b1 && exp_i_q.size() > 0) begin
            exp_v = exp_i_q.pop_front();
            checks++; if (bus.i_data_out !== exp_v) begin failures++; $display("FAIL sw_i_data got=%h exp=%h", bus.i_data_out, exp_v); end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                bus.i_req = 1'b1;
                bus.i_addr = 16'h0200;
                bus.d_rd = 1'b1;
                bus.d_addr = 16'h0100;
                bus.mem_done = 1'b1;
                rd = $urandom;
                bus.mem_data_out = rd;
                if (k < 4) exp_d_q.push_back(rd);
                else       exp_i_q.push_back(rd);
                #1;
                checks++; if (bus.d_done !== (k < 4)) begin failures++; $display("FAIL st_d_done r=%0d k=%0d got=%0d exp=%0d", r, k, bus.d_done, (k < 4)); end
                checks++; if (bus.i_done !== (k == 4)) begin failures++; $display("FAIL st_i_done r=%0d k=%0d got=%0d exp=%0d", r, k, bus.i_done, (k == 4)); end
                checks++; if (bus.mem_addr !== ((k < 4) ? 16'h0100 : 16'h0200)) begin failures++; $display("FAIL st_addr r=%0d k=%0d got=%h", r, k, bus.mem_addr); end
                if (bus.d_done === 1'b1 && exp_d_q.size() > 0) begin
                    exp_v = exp_d_q.pop_front();
                    checks++; if (bus.d_data_out !== exp_v) begin failures++; $display("FAIL st_d_data got=%h exp=%h", bus.d_data_out, exp_v); end
                end
                if (bus.i_done === 1'b1 && exp_i_q.size() > 0) begin
                    exp_v = exp_i_q.pop_front();
                    checks++; if (bus.i_data_out !== exp_v) begin failures++; $display("FAIL st_i_data got=%h exp=%h", bus.i_data_out, exp_v); end
                end
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_err();
        @(negedge clk);
        bus.d_rd = 1'b1;
        bus.d_addr = 16'h0002;
        bus.mem_done = 1'b1;
        bus.mem_err = 1'b1;
        rd = $urandom;
        bus.mem_data_out = rd;
        exp_d_q.push_back(rd);
        #1;
        checks++; if (bus.d_done !== 1'b1) begin failures++; $display("FAIL err_d_done got=%0d exp=1", bus.d_done); end
        checks++; if (bus.d_err !== 1'b1) begin failures++; $display("FAIL err_d_err got=%0d exp=1", bus.d_err); end
        checks++; if (bus.i_err !== 1'b0) begin failures++; $display("FAIL err_i_err got=%0d exp=0", bus.i_err); end
        if (bus.d_done === 1'b1 && exp_d_q.size() > 0) begin
            exp_v = exp_d_q.pop_front();
            checks++; if (bus.d_data_out !== exp_v) begin failures++; $display("FAIL err_d_data got=%h exp=%h", bus.d_data_out, exp_v); end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        bus.i_req = 1'b1;
        bus.i_addr = 16'h0030;
        bus.mem_stall = 1'b1;
        #1;
        checks++; if (bus.mem_rd !== 1'b1 || bus.i_done !== 1'b0) begin failures++; $display("FAIL rs_stall got=%0d/%0d exp=1/0", bus.mem_rd, bus.i_done); end
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rs_locked got=%0d exp=1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_rd !== 1'b0) begin failures++; $display("FAIL rs_mem_rd got=%0d exp=0", bus.mem_rd); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rs_busy got=%0d exp=0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_stall = 1'b0;
        bus.mem_done = 1'b1;
        rd = $urandom;
        bus.mem_data_out = rd;
        exp_i_q.push_back(rd);
        #1;
        checks++; if (bus.i_done !== 1'b1 || bus.mem_rd !== 1'b1) begin failures++; $display("FAIL rs_fresh got=%0d/%0d exp=1/1", bus.i_done, bus.mem_rd); end
        if (bus.i_done === 1'b1 && exp_i_q.size() > 0) begin
            exp_v = exp_i_q.pop_front();
            checks++; if (bus.i_data_out !== exp_v) begin failures++; $display("FAIL rs_i_data got=%h exp=%h", bus.i_data_out, exp_v); end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_proto();
        @(negedge clk);
        bus.d_rd = 1'b1;
        bus.d_wr = 1'b1;
        bus.d_addr = 16'h0044;
        bus.d_data_in = 32'h1234_5678;
        bus.mem_done = 1'b1;
        #1;
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL pr_before got=%0d exp=0", bus.proto_err); end
        checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin failures++; $display("FAIL pr_write got=%0d/%0d exp=1/0", bus.mem_wr, bus.mem_rd); end
        checks++; if (bus.d_done !== 1'b1) begin failures++; $display("FAIL pr_d_done got=%0d exp=1", bus.d_done); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (bus.proto_err !== 1'b1) begin failures++; $display("FAIL pr_sticky got=%0d exp=1", bus.proto_err); end
        do_reset();
        #1;
        checks++; if (bus.proto_err !== 1'b0) begin failures++; $display("FAIL pr_cleared got=%0d exp=0", bus.proto_err); end
        // Locked data requester drops its request mid-stall.
        @(negedge clk);
        bus.d_rd = 1'b1;
        bus.d_addr = 16'h0048;
        bus.mem_stall = 1'b1;
        @(negedge clk);
        bus.d_rd = 1'b0;
        bus.mem_stall = 1'b0;
        bus.mem_done = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL pr_drop_busy got=%0d exp=1", bus.busy); end
        checks++; if (bus.d_done !== 1'b0 || bus.mem_rd !== 1'b0) begin failures++; $display("FAIL pr_drop_done got=%0d/%0d exp=0/0", bus.d_done, bus.mem_rd); end
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL pr_drop_free got=%0d exp=0", bus.busy); end
        checks++; if (bus.proto_err !== 1'b1) begin failures++; $display("FAIL pr_drop_flag got=%0d exp=1", bus.proto_err); end
        do_reset();
    endtask

    task automatic test_perf();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.i_req = 1'b1;
            bus.i_addr = 16'h0050;
            bus.mem_stall = (c < 3);
            bus.mem_done = (c == 3);
        end
        @(negedge clk);
        drive_idle();
        #1;
`ifdef MEM_ARB_PERF_EN
        checks++; if (bus.perf_stall !== 32'd3) begin failures++; $display("FAIL perf_stall got=%0d exp=3", bus.perf_stall); end
        checks++; if (bus.perf_igrant !== 32'd1) begin failures++; $display("FAIL perf_igrant got=%0d exp=1", bus.perf_igrant); end
        checks++; if (bus.perf_dgrant !== 32'd0) begin failures++; $display("FAIL perf_dgrant got=%0d exp=0", bus.perf_dgrant); end
`else
        checks++; if (bus.perf_stall !== 32'd0 || bus.perf_igrant !== 32'd0 || bus.perf_dgrant !== 32'd0) begin
            failures++; $display("FAIL perf_tied got=%0d/%0d/%0d exp=0/0/0", bus.perf_stall, bus.perf_igrant, bus.perf_dgrant);
        end
`endif
    endtask

    // Scenario sequence and final report.
    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_zero_latency();
        test_stall_write();
        test_starvation();
        test_err();
        test_reset_mid_stall();
        test_proto();
        test_perf();
        checks++; if (exp_i_q.size() != 0) begin failures++; $display("FAIL sb_i_left got=%0d exp=0", exp_i_q.size()); end
        checks++; if (exp_d_q.size() != 0) begin failures++; $display("FAIL sb_d_left got=%0d exp=0", exp_d_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter in front of the single shared, stalling unified memory (word-aligned, 32-bit data, 16-bit byte address, Done/Stall handshake).
- Arbitrates between the fetch port (read-only) and the data port (read/write).
- Locks the grant across memory stall cycles.
- Routes completion, read data and error back to the winning requester.
- Sits between the pipeline IF/MEM stages and the memory.

Parameters:
ADDR_W, 16, address width in bits (byte address)
DATA_W, 32, data width in bits
MAX_WAIT, 4, completed data accesses tolerated while a fetch waits before fetch is forced to win (1..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch read request; held until i_done
i_addr  in  ADDR_W  fetch address
i_data_out  out  DATA_W  fetch read data; valid when i_done=1
i_done  out  1  fetch access completes this cycle
i_err  out  1  memory err for the fetch access; qualified by i_done
d_rd  in  1  data read request; held until d_done
d_wr  in  1  data write request; held until d_done
d_addr  in  ADDR_W  data address
d_data_in  in  DATA_W  write data
d_data_out  out  DATA_W  data read data; valid when d_done=1 and the access is a read
d_done  out  1  data access completes this cycle
d_err  out  1  memory err for the data access; qualified by d_done
mem_rd, mem_wr  out  1 each  memory read/write strobes
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data (combinational)
mem_done  in  1  memory ready; the access takes effect this cycle
mem_stall  in  1  memory stalled this cycle
mem_err  in  1  misaligned-access error from memory
busy  out  1  lock != NONE
proto_err  out  1  sticky protocol-violation flag
perf_stall  out  32  memory stall cycle count (feature only)
perf_igrant  out  32  completed fetch access count (feature only)
perf_dgrant  out  32  completed data access count (feature only)

Behaviour:
- State is a lock register {NONE, I, D} plus a 3-bit saturating starvation counter wait_cnt. Reset: lock=NONE, wait_cnt=0, proto_err=0, perf counters 0.
- All done/err/strobe outputs are combinational from lock, the requests and the memory inputs. Data outputs are 0 when not done.
- With lock=NONE, sel is computed in the same cycle:
  - d wins if d_rd|d_wr, unless i_req=1 and wait_cnt>=MAX_WAIT, in which case i wins.
  - Otherwise i wins if i_req.
  - Otherwise there is no access.
- With lock!=NONE, sel=lock. The other requester sees no done.
- Memory drive: sel=I gives mem_rd=1, mem_addr=i_addr. sel=D gives mem_rd=d_rd&~d_wr, mem_wr=d_wr, mem_addr=d_addr, mem_data_in=d_data_in.
- Zero-latency hit: if the access is issued and mem_done=1, done is asserted for sel in the same cycle, data=mem_data_out, err=mem_err. lock becomes or stays NONE.
- Stall: mem_stall=1 gives lock<=sel on the next edge. Requests are held and re-driven every cycle until mem_done.
- Starvation counter:
  - wait_cnt increments (saturating at 7) on each d completion while i_req=1.
  - wait_cnt clears on i completion.
  - Once locked on D, a new i_req does not preempt.
- Protocol violations set proto_err and hold it until reset:
  - d_rd&d_wr together: treated as a write.
  - The locked requester drops its request before done: lock returns to NONE next edge, no done is issued.
- Reset mid-stall: lock clears asynchronously and mem_rd/mem_wr go to 0 immediately while rst_n=0.
- No requests: mem strobes are 0 and busy=0.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: perf_stall increments on each cycle with mem_stall=1. perf_igrant and perf_dgrant increment on i_done and d_done. All three are 32-bit wrapping counters, cleared by reset.
- Undefined: the perf_* ports are tied to 0 and no counter flops are built.

Test Plan:
- i_req=1, i_addr=0x0010, mem_done=1 in the same cycle -> i_done=1 that cycle, i_data_out=mem_data_out, busy=0.
- i_req and d_wr both raised, mem_stall for 2 cycles -> mem_wr=1 for 3 cycles with d_addr, d_done on cycle 3, then i serviced; i_done never asserted during the D lock.
- i_req held while 4 back-to-back d_rd complete with MAX_WAIT=4 -> the 5th arbitration grants I despite d_rd=1; wait_cnt returns to 0 after i_done.
- d_rd at address 0x0002 with mem_err=1 and mem_done=1 -> d_done=1, d_err=1, i_err=0.
- Locked on I during a stall, then rst_n pulled low -> mem_rd=0 immediately, busy=0; after release, a fresh i_req is serviced normally.
- d_rd=d_wr=1 -> a write is issued and proto_err=1 until reset. With MEM_ARB_PERF_EN, 3 stall cycles -> perf_stall=3.
